// File: rtl/prbs_check_pkg.sv
// Shared types and helpers for the PRBS checker.
package prbs_check_pkg;

  typedef enum logic [1:0] {
    ST_FILL   = 2'd0,
    ST_HUNT   = 2'd1,
    ST_LOCKED = 2'd2
  } lock_state_t;

  function automatic int ceil_div(input int num, input int den);
    return (num + den - 1) / den;
  endfunction

endpackage

// File: rtl/lfsr.sv
// Combinational parallel LFSR, advancing DATA_WIDTH bit times per evaluation.
// In feed-forward mode the received bits are shifted into the state, so
// data_out is the descrambled word (zero for a clean PRBS stream).
module lfsr #(
  parameter int                    LFSR_WIDTH        = 31,
  parameter logic [LFSR_WIDTH-1:0] LFSR_POLY         = 31'h10000001,
  parameter string                 LFSR_CONFIG       = "FIBONACCI",
  parameter bit                    LFSR_FEED_FORWARD = 1'b0,
  parameter bit                    REVERSE           = 1'b0,
  parameter int                    DATA_WIDTH        = 8
) (
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic [LFSR_WIDTH-1:0] state_in,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic [LFSR_WIDTH-1:0] state_out
);

  localparam bit GALOIS = (LFSR_CONFIG == "GALOIS");

  // Unrolled bit-serial step: one shift per data bit, MSB first unless REVERSE.
  always_comb begin
    logic [LFSR_WIDTH-1:0] st;
    logic                  fb;
    int                    idx;
    st       = state_in;
    data_out = '0;
    fb       = 1'b0;
    idx      = 0;
    for (int k = 0; k < DATA_WIDTH; k++) begin
      idx = REVERSE ? k : DATA_WIDTH - 1 - k;
      fb  = st[LFSR_WIDTH-1] ^ data_in[idx];
      if (GALOIS) begin
        st = {st[LFSR_WIDTH-2:0], (LFSR_FEED_FORWARD ? data_in[idx] : fb)};
        st = st ^ ({LFSR_POLY[LFSR_WIDTH-1:1], 1'b0} & {LFSR_WIDTH{fb}});
      end else begin
        // Poly bit j taps the state bit that is j shifts old; bit 0 is the +1 term.
        for (int j = 1; j < LFSR_WIDTH; j++) begin
          if (LFSR_POLY[j]) fb = fb ^ st[j-1];
        end
        st = {st[LFSR_WIDTH-2:0], (LFSR_FEED_FORWARD ? data_in[idx] : fb)};
      end
      data_out[idx] = fb;
    end
    state_out = st;
  end

endmodule

// File: rtl/prbs_check.sv
// Self-synchronising PRBS checker: per-bit error flags, lock tracking and a
// saturating bit-error counter for BER measurement.
//
// state  | meaning
// FILL   | priming the feed-forward register, errors ignored
// HUNT   | waiting for LOCK_COUNT consecutive clean words
// LOCKED | in sync, counting bit errors; UNLOCK_COUNT errored words drop lock
module prbs_check
  import prbs_check_pkg::*;
#(
  parameter int                    LFSR_WIDTH    = 31,
  parameter logic [LFSR_WIDTH-1:0] LFSR_POLY     = 31'h10000001,
  parameter string                 LFSR_CONFIG   = "FIBONACCI",
  parameter bit                    REVERSE       = 1'b0,
  parameter bit                    INVERT        = 1'b1,
  parameter int                    DATA_WIDTH    = 8,
  parameter int                    LOCK_COUNT    = 16,
  parameter int                    UNLOCK_COUNT  = 4,
  parameter int                    ERR_CNT_WIDTH = 32
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [DATA_WIDTH-1:0]    s_data,
  input  logic                     s_valid,
  input  logic                     clear,
  output logic [DATA_WIDTH-1:0]    err_bits,
  output logic                     err_valid,
  output logic                     locked,
  output logic                     lock_lost,
  output logic [ERR_CNT_WIDTH-1:0] err_count,
  output logic                     err_sat
);

  localparam int FILL_WORDS = ceil_div(LFSR_WIDTH, DATA_WIDTH);
  localparam int POP_WIDTH  = $clog2(DATA_WIDTH + 1);
  localparam int FILL_CW    = $clog2(FILL_WORDS + 1);
  localparam int GOOD_CW    = $clog2(LOCK_COUNT + 1);
  localparam int BAD_CW     = $clog2(UNLOCK_COUNT + 1);
  localparam logic [ERR_CNT_WIDTH-1:0] CNT_MAX = '1;

  logic [LFSR_WIDTH-1:0]  state_reg;
  logic [LFSR_WIDTH-1:0]  lfsr_state_out;
  logic [DATA_WIDTH-1:0]  raw_err;
  logic [DATA_WIDTH-1:0]  err_bits_next;
  logic                   word_err;
  logic [POP_WIDTH-1:0]   pop_cnt;

  lock_state_t            st, st_next;
  logic [FILL_CW-1:0]     fill_cnt, fill_next;
  logic [GOOD_CW-1:0]     good_cnt, good_next;
  logic [BAD_CW-1:0]      bad_cnt, bad_next;
  logic                   lock_lost_next;
  logic                   count_en;
  logic [ERR_CNT_WIDTH:0] sum_ext;

  lfsr #(
    .LFSR_WIDTH       (LFSR_WIDTH),
    .LFSR_POLY        (LFSR_POLY),
    .LFSR_CONFIG      (LFSR_CONFIG),
    .LFSR_FEED_FORWARD(1'b1),
    .REVERSE          (REVERSE),
    .DATA_WIDTH       (DATA_WIDTH)
  ) prbs_lfsr_inst (
    .data_in  (s_data),
    .state_in (state_reg),
    .data_out (raw_err),
    .state_out(lfsr_state_out)
  );

  // Inverted PRBS variants descramble to all-ones on a clean stream.
  assign err_bits_next = raw_err ^ {DATA_WIDTH{INVERT}};
  assign word_err      = |err_bits_next;

  // Bit-error popcount of the incoming word.
  always_comb begin
    pop_cnt = '0;
    for (int i = 0; i < DATA_WIDTH; i++) begin
      pop_cnt = pop_cnt + POP_WIDTH'(err_bits_next[i]);
    end
  end

  // Lock FSM next-state and run counters; advances only on accepted words.
  always_comb begin
    st_next        = st;
    fill_next      = fill_cnt;
    good_next      = good_cnt;
    bad_next       = bad_cnt;
    lock_lost_next = 1'b0;
    count_en       = 1'b0;
    if (s_valid) begin
      case (st)
        ST_FILL: begin
          if (fill_cnt == FILL_CW'(FILL_WORDS - 1)) begin
            st_next   = ST_HUNT;
            fill_next = '0;
          end else begin
            fill_next = fill_cnt + 1'b1;
          end
        end
        ST_HUNT: begin
          if (word_err) begin
            good_next = '0;
          end else if (good_cnt == GOOD_CW'(LOCK_COUNT - 1)) begin
            st_next   = ST_LOCKED;
            good_next = '0;
          end else begin
            good_next = good_cnt + 1'b1;
          end
        end
        ST_LOCKED: begin
          count_en = 1'b1;
          if (!word_err) begin
            bad_next = '0;
          end else if (bad_cnt == BAD_CW'(UNLOCK_COUNT - 1)) begin
            // Feed-forward state is already current, so no refill is needed.
            st_next        = ST_HUNT;
            bad_next       = '0;
            lock_lost_next = 1'b1;
          end else begin
            bad_next = bad_cnt + 1'b1;
          end
        end
        default: st_next = ST_FILL;
      endcase
    end
  end

  // Lock FSM state and counter registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      st        <= ST_FILL;
      fill_cnt  <= '0;
      good_cnt  <= '0;
      bad_cnt   <= '0;
      lock_lost <= 1'b0;
    end else begin
      st        <= st_next;
      fill_cnt  <= fill_next;
      good_cnt  <= good_next;
      bad_cnt   <= bad_next;
      lock_lost <= lock_lost_next;
    end
  end

  assign locked  = (st == ST_LOCKED);
  assign sum_ext = {1'b0, err_count} + (ERR_CNT_WIDTH + 1)'(pop_cnt);

  // Descrambler state, error word output and saturating error counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= '0;
      err_bits  <= '0;
      err_valid <= 1'b0;
      err_count <= '0;
      err_sat   <= 1'b0;
    end else begin
      if (s_valid) begin
        state_reg <= lfsr_state_out;
        err_bits  <= err_bits_next;
        err_valid <= 1'b1;
      end else begin
        err_valid <= 1'b0;
      end
      if (clear) begin
        err_count <= '0;
        err_sat   <= 1'b0;
      end else if (count_en) begin
        if (sum_ext >= {1'b0, CNT_MAX}) begin
          err_count <= CNT_MAX;
          err_sat   <= 1'b1;
        end else begin
          err_count <= sum_ext[ERR_CNT_WIDTH-1:0];
        end
      end
    end
  end

endmodule

// File: tb/tb_prbs_check.sv
// Bench for prbs_check: inverted PRBS31 stream with random gaps, bit flips and
// clears, compared every cycle against a bit-level reference model.
module tb_prbs_check;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] s_data;
  logic       s_valid;
  logic       clear;

  logic [7:0]  err_bits,   n_err_bits;
  logic        err_valid,  n_err_valid;
  logic        locked,     n_locked;
  logic        lock_lost,  n_lock_lost;
  logic [31:0] err_count;
  logic [3:0]  n_err_count;
  logic        err_sat,    n_err_sat;

  always #5 clk = ~clk;

  prbs_check dut (
    .clk(clk), .rst(rst), .s_data(s_data), .s_valid(s_valid), .clear(clear),
    .err_bits(err_bits), .err_valid(err_valid), .locked(locked),
    .lock_lost(lock_lost), .err_count(err_count), .err_sat(err_sat)
  );

  prbs_check #(.ERR_CNT_WIDTH(4)) dut_n (
    .clk(clk), .rst(rst), .s_data(s_data), .s_valid(s_valid), .clear(clear),
    .err_bits(n_err_bits), .err_valid(n_err_valid), .locked(n_locked),
    .lock_lost(n_lock_lost), .err_count(n_err_count), .err_sat(n_err_sat)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // PRBS31 generator: x[t] = x[t-28] ^ x[t-31], transmitted inverted, MSB first.
  bit gen_hist[$];

  task automatic next_word(output logic [7:0] w);
    bit x;
    for (int k = 7; k >= 0; k--) begin
      x = gen_hist[gen_hist.size() - 28] ^ gen_hist[gen_hist.size() - 31];
      gen_hist.push_back(x);
      w[k] = ~x;
    end
  endtask

  // Reference model, expressed in received-bit history and word run lengths.
  bit          rx_hist[$];
  int          m_words;
  bit          m_locked;
  int          m_good, m_bad;
  logic [7:0]  m_bits;
  bit          m_valid, m_lost;
  longint      m_cnt32;
  bit          m_sat32;
  int          m_cnt4;
  bit          m_sat4;

  function automatic bit rx_prev(input int k);
    return (rx_hist.size() >= k) ? rx_hist[rx_hist.size() - k] : 1'b0;
  endfunction

  task automatic model_reset();
    rx_hist.delete();
    m_words = 0; m_locked = 0; m_good = 0; m_bad = 0;
    m_bits = '0; m_valid = 0; m_lost = 0;
    m_cnt32 = 0; m_sat32 = 0; m_cnt4 = 0; m_sat4 = 0;
  endtask

  task automatic model_step(input bit v, input logic [7:0] d, input bit c);
    logic [7:0] e;
    int         pop;
    bit         was_locked;
    e = '0; pop = 0; was_locked = 0;
    m_valid = v;
    m_lost  = 0;
    if (v) begin
      for (int k = 7; k >= 0; k--) begin
        e[k] = 1'b1 ^ d[k] ^ rx_prev(28) ^ rx_prev(31);
        rx_hist.push_back(d[k]);
      end
      m_bits     = e;
      pop        = $countones(e);
      was_locked = m_locked;
      if (m_words < 4) begin
        m_words++;
      end else if (!m_locked) begin
        if (e != 0) m_good = 0;
        else begin
          m_good++;
          if (m_good == 16) begin m_locked = 1; m_good = 0; end
        end
      end else begin
        if (e != 0) begin
          m_bad++;
          if (m_bad == 4) begin m_locked = 0; m_bad = 0; m_lost = 1; end
        end else m_bad = 0;
      end
    end
    if (c) begin
      m_cnt32 = 0; m_sat32 = 0; m_cnt4 = 0; m_sat4 = 0;
    end else if (was_locked) begin
      m_cnt32 += pop;
      if (m_cnt32 >= 64'hFFFF_FFFF) begin m_cnt32 = 64'hFFFF_FFFF; m_sat32 = 1; end
      m_cnt4 += pop;
      if (m_cnt4 >= 15) begin m_cnt4 = 15; m_sat4 = 1; end
    end
  endtask

  task automatic compare_all();
    check_eq("err_valid",   err_valid,   m_valid);
    check_eq("err_bits",    err_bits,    m_bits);
    check_eq("locked",      locked,      m_locked);
    check_eq("lock_lost",   lock_lost,   m_lost);
    check_eq("err_count",   err_count,   m_cnt32);
    check_eq("err_sat",     err_sat,     m_sat32);
    check_eq("n_err_valid", n_err_valid, m_valid);
    check_eq("n_err_bits",  n_err_bits,  m_bits);
    check_eq("n_locked",    n_locked,    m_locked);
    check_eq("n_lock_lost", n_lock_lost, m_lost);
    check_eq("n_err_count", n_err_count, m_cnt4);
    check_eq("n_err_sat",   n_err_sat,   m_sat4);
  endtask

  int acc_words;
  int lock_at;
  int lost_pulses;

  task automatic step(input bit v, input logic [7:0] d, input bit c);
    s_valid = v; s_data = d; clear = c;
    @(posedge clk); #1;
    model_step(v, d, c);
    compare_all();
    if (v) acc_words++;
    if (locked && lock_at < 0) lock_at = acc_words;
    if (lock_lost) lost_pulses++;
  endtask

  task automatic step_prbs(input bit v, input logic [7:0] flip, input bit c);
    logic [7:0] w;
    if (v) begin
      next_word(w);
      w = w ^ flip;
    end else begin
      w = 8'($urandom);
    end
    step(v, w, c);
  endtask

  task automatic do_reset();
    rst = 1; s_valid = 0; clear = 0; s_data = '0;
    @(posedge clk); #1;
    model_reset();
    compare_all();
    rst = 0;
  endtask

  task automatic start_phase();
    acc_words = 0; lock_at = -1; lost_pulses = 0;
  endtask

  function automatic logic [7:0] one_bit();
    logic [7:0] m;
    m = 8'h01;
    return m << $urandom_range(0, 7);
  endfunction

  initial begin
    for (int i = 0; i < 31; i++) gen_hist.push_back(1'($urandom));
    gen_hist[0] = 1'b1;
    rst = 1; s_valid = 0; clear = 0; s_data = '0;
    repeat (2) @(posedge clk);
    do_reset();

    // Continuous clean stream: 4 fill words + 16 clean words to lock.
    start_phase();
    repeat (24) step_prbs(1, 8'h00, 0);
    check_eq("lock_word_cont", lock_at, 20);
    check_eq("count_clean", err_count, 0);

    // Single bit flip while locked yields the bit and its two echoes.
    step_prbs(1, one_bit(), 0);
    repeat (6) step_prbs(1, 8'h00, 0);
    check_eq("single_flip_count", err_count, 3);
    check_eq("single_flip_locked", locked, 1);

    // Four fully inverted words drop lock, then the stream relocks.
    start_phase();
    repeat (4) step_prbs(1, 8'hFF, 0);
    check_eq("burst_lock_lost", lock_lost, 1);
    check_eq("burst_locked", locked, 0);
    check_eq("burst_count", err_count, 32);
    repeat (30) step_prbs(1, 8'h00, 0);
    check_eq("burst_pulses", lost_pulses, 1);
    check_eq("burst_relock", locked, 1);
    check_eq("narrow_sat_count", n_err_count, 15);
    check_eq("narrow_sat_flag", n_err_sat, 1);

    // Clear, then saturate the narrow counter again, then clear against an increment.
    step_prbs(1, 8'h00, 1);
    check_eq("clear_alone", n_err_count, 0);
    repeat (6) begin
      step_prbs(1, one_bit(), 0);
      repeat (5) step_prbs(1, 8'h00, 0);
    end
    check_eq("resat_count", n_err_count, 15);
    check_eq("resat_flag", n_err_sat, 1);
    step_prbs(1, one_bit(), 1);
    check_eq("clear_prio_count", n_err_count, 0);
    check_eq("clear_prio_sat", n_err_sat, 0);
    repeat (6) step_prbs(1, 8'h00, 0);

    // Valid every other cycle: lock timing is counted in accepted words.
    do_reset();
    start_phase();
    for (int i = 0; i < 48; i++) step_prbs((i % 2) == 0, 8'h00, 0);
    check_eq("lock_word_toggle", lock_at, 20);

    // Random gaps, occasional bit flips and clears.
    for (int i = 0; i < 400; i++) begin
      step_prbs($urandom_range(0, 3) != 0,
                ($urandom_range(0, 19) == 0) ? one_bit() : 8'h00,
                $urandom_range(0, 49) == 0);
    end

    // Reset while locked; relock needs a full fill and hunt again.
    repeat (30) step_prbs(1, 8'h00, 0);
    check_eq("pre_rst_locked", locked, 1);
    do_reset();
    check_eq("rst_locked", locked, 0);
    check_eq("rst_err_valid", err_valid, 0);
    start_phase();
    repeat (24) step_prbs(1, 8'h00, 0);
    check_eq("lock_word_rst", lock_at, 20);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
